// File: rtl/aes_pkg.sv
// Shared AES datapath constants: state/CPU widths, byte-slice helpers, CSR codes
// and the InvShiftRows byte routing used by the decrypt path.
package aes_pkg;

  localparam int BLOCK_DATA_WIDTH = 128;
  localparam int CPU_DATA_WIDTH   = 32;
  localparam int CNT_WIDTH        = 8;

  localparam int BYTE_WIDTH = 8;
  localparam int NUM_ROWS   = 4;
  localparam int NUM_COLS   = 4;
  localparam int NUM_BYTES  = NUM_ROWS * NUM_COLS;
  localparam int NUM_PNTR   = 4;
  localparam int PNTR_WIDTH = 2;

  localparam logic CNT_REG = 1'b0;
  localparam logic DBG_REG = 1'b1;

  localparam int DBG_RD_AND_VALID = 0;
  localparam int DBG_STALL_SEEN   = 1;
  localparam int DBG_WIDTH        = 2;

  // State bytes are column-major: byte k sits at row k%4, column k/4, MSB first.
  function automatic int byte_index(input int row, input int col);
    return NUM_ROWS * col + row;
  endfunction

  function automatic int byte_msb(input int k);
    return BLOCK_DATA_WIDTH - 1 - BYTE_WIDTH * k;
  endfunction

  // Row r is rotated right by r bytes: out(r,c) = in(r,(c-r) mod 4).
  function automatic logic [BLOCK_DATA_WIDTH-1:0] inv_shift_rows_f(
    input logic [BLOCK_DATA_WIDTH-1:0] state_in
  );
    logic [BLOCK_DATA_WIDTH-1:0] state_out;
    state_out = '0;
    for (int col = 0; col < NUM_COLS; col++) begin
      for (int row = 0; row < NUM_ROWS; row++) begin
        state_out[byte_msb(byte_index(row, col)) -: BYTE_WIDTH] =
          state_in[byte_msb(byte_index(row, (col - row + NUM_COLS) % NUM_COLS)) -: BYTE_WIDTH];
      end
    end
    return state_out;
  endfunction

endpackage

// File: rtl/inv_shift_rows_csr.sv
// Per-pointer transfer counters, sticky debug flags (clear-on-read) and the
// registered CPU read port for the InvShiftRows stage.
module inv_shift_rows_csr
  import aes_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      accept,
  input  logic [PNTR_WIDTH-1:0]     accept_pntr,
  input  logic                      stall_seen,
  input  logic                      cpu_rd,
  input  logic                      cpu_addr,
  output logic [CPU_DATA_WIDTH-1:0] cpu_rd_data,
  output logic                      cpu_rd_data_vld
);

  logic [NUM_PNTR-1:0][CNT_WIDTH-1:0] cnt_d, cnt_q;
  logic [DBG_WIDTH-1:0]               dbg_d, dbg_q;
  logic [CPU_DATA_WIDTH-1:0]          rd_data_d, rd_data_q;
  logic                               rd_vld_d, rd_vld_q;
  logic [CPU_DATA_WIDTH-1:0]          reg_val;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d[accept_pntr] = cnt_q[accept_pntr] + 1'b1;
    end
  end

  // Clear-on-read happens first so a set condition in the same cycle wins.
  always_comb begin
    dbg_d = dbg_q;
    if (cpu_rd && (cpu_addr == DBG_REG)) begin
      dbg_d = '0;
    end
    if (cpu_rd && accept) begin
      dbg_d[DBG_RD_AND_VALID] = 1'b1;
    end
    if (stall_seen) begin
      dbg_d[DBG_STALL_SEEN] = 1'b1;
    end
  end

  // Reads return the pre-update register contents of the strobe cycle.
  always_comb begin
    if (cpu_addr == CNT_REG) begin
      reg_val = cnt_q;
    end else begin
      reg_val = {{(CPU_DATA_WIDTH - DBG_WIDTH){1'b0}}, dbg_q};
    end
    rd_data_d = cpu_rd ? reg_val : rd_data_q;
    rd_vld_d  = cpu_rd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      dbg_q     <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dbg_q     <= dbg_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  assign cpu_rd_data     = rd_data_q;
  assign cpu_rd_data_vld = rd_vld_q;

endmodule

// File: rtl/inv_shift_rows.sv
// AES InvShiftRows stage: one registered pipeline slot with valid/ready
// handshake, a key-pointer tag carried alongside, and a small CSR block.
module inv_shift_rows #(
  parameter int BLOCK_DATA_WIDTH = aes_pkg::BLOCK_DATA_WIDTH,
  parameter int CPU_DATA_WIDTH   = aes_pkg::CPU_DATA_WIDTH,
  parameter int CNT_WIDTH        = aes_pkg::CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [BLOCK_DATA_WIDTH-1:0] data_in,
  input  logic                        data_in_vld,
  output logic                        data_in_rdy,
  input  logic [1:0]                  pntr_num_in,
  output logic [BLOCK_DATA_WIDTH-1:0] data_out,
  output logic                        data_out_vld,
  input  logic                        data_out_rdy,
  output logic [1:0]                  pntr_num_out,
  input  logic                        cpu_rd,
  input  logic                        cpu_addr,
  output logic [CPU_DATA_WIDTH-1:0]   cpu_rd_data,
  output logic                        cpu_rd_data_vld
);
  import aes_pkg::*;

  logic [BLOCK_DATA_WIDTH-1:0] data_out_d, data_out_q;
  logic                        out_vld_d, out_vld_q;
  logic [1:0]                  pntr_out_d, pntr_out_q;
  logic                        accept;
  logic                        stall_seen;

  // The slot can take a new state whenever it is empty or draining this cycle.
  assign data_in_rdy = !out_vld_q || data_out_rdy;
  assign accept      = data_in_vld && data_in_rdy;
  assign stall_seen  = data_in_vld && !data_in_rdy;

  always_comb begin
    data_out_d = data_out_q;
    pntr_out_d = pntr_out_q;
    out_vld_d  = out_vld_q;
    if (accept) begin
      data_out_d = inv_shift_rows_f(data_in);
      pntr_out_d = pntr_num_in;
      out_vld_d  = 1'b1;
    end else if (data_out_rdy) begin
      out_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q <= '0;
      pntr_out_q <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      pntr_out_q <= pntr_out_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign data_out     = data_out_q;
  assign pntr_num_out = pntr_out_q;
  assign data_out_vld = out_vld_q;

  inv_shift_rows_csr u_csr (
    .clk             (clk),
    .reset           (reset),
    .accept          (accept),
    .accept_pntr     (pntr_num_in),
    .stall_seen      (stall_seen),
    .cpu_rd          (cpu_rd),
    .cpu_addr        (cpu_addr),
    .cpu_rd_data     (cpu_rd_data),
    .cpu_rd_data_vld (cpu_rd_data_vld)
  );

endmodule

// File: tb/tb_inv_shift_rows.sv
// Scoreboard bench for inv_shift_rows: a driver pushes expected results from a
// matrix-level model, an independent monitor pops them as the DUT presents them.
module tb_inv_shift_rows;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] data_in;
  logic         data_in_vld;
  logic         data_in_rdy;
  logic [1:0]   pntr_num_in;
  logic [127:0] data_out;
  logic         data_out_vld;
  logic         data_out_rdy;
  logic [1:0]   pntr_num_out;
  logic         cpu_rd;
  logic         cpu_addr;
  logic [31:0]  cpu_rd_data;
  logic         cpu_rd_data_vld;

  inv_shift_rows dut (
    .clk             (clk),
    .reset           (reset),
    .data_in         (data_in),
    .data_in_vld     (data_in_vld),
    .data_in_rdy     (data_in_rdy),
    .pntr_num_in     (pntr_num_in),
    .data_out        (data_out),
    .data_out_vld    (data_out_vld),
    .data_out_rdy    (data_out_rdy),
    .pntr_num_out    (pntr_num_out),
    .cpu_rd          (cpu_rd),
    .cpu_addr        (cpu_addr),
    .cpu_rd_data     (cpu_rd_data),
    .cpu_rd_data_vld (cpu_rd_data_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [1:0]   pntr;
  } out_t;

  out_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  logic [7:0]  m_cnt[4];
  logic [1:0]  m_dbg;
  logic        m_vld;

  // Reference: view the state as a 4x4 byte matrix and rotate each row right by its index.
  function automatic logic [127:0] ref_inv_shift(input logic [127:0] s);
    logic [7:0]   mat[4][4];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) mat[k % 4][k / 4] = s[127 - 8*k -: 8];
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127 - 8*(4*c + r) -: 8] = mat[r][(c - r + 4) % 4];
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    rd_q.delete();
    for (int p = 0; p < 4; p++) m_cnt[p] = 8'h00;
    m_dbg = 2'b00;
    m_vld = 1'b0;
  endtask

  // One clock cycle: drive after the edge, then update the model mid-cycle.
  task automatic applyStimulus(input logic vld, input logic [127:0] d, input logic [1:0] p,
                               input logic ordy, input logic rd, input logic addr);
    logic rdy;
    logic acc;
    out_t e;
    @(posedge clk);
    #1;
    data_in_vld  = vld;
    data_in      = d;
    pntr_num_in  = p;
    data_out_rdy = ordy;
    cpu_rd       = rd;
    cpu_addr     = addr;
    @(negedge clk);
    rdy = !m_vld || ordy;
    acc = vld && rdy;
    checkOutput("data_in_rdy", data_in_rdy, rdy);
    if (rd) rd_q.push_back(addr ? {30'b0, m_dbg} : {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
    if (rd && addr) m_dbg = 2'b00;
    if (rd && acc) m_dbg[0] = 1'b1;
    if (vld && !rdy) m_dbg[1] = 1'b1;
    if (acc) begin
      e.data = ref_inv_shift(d);
      e.pntr = p;
      exp_q.push_back(e);
      m_cnt[p] = m_cnt[p] + 8'd1;
      m_vld = 1'b1;
    end else if (ordy) begin
      m_vld = 1'b0;
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: pops expectations only when the DUT itself presents a transfer or read.
  always @(negedge clk) begin
    out_t        e;
    logic [31:0] r;
    if (!reset && data_out_vld && data_out_rdy) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL unexpected_output: got %h expected none", data_out);
      end else begin
        e = exp_q.pop_front();
        checkOutput("data_out", data_out, e.data);
        checkOutput("pntr_num_out", {126'b0, pntr_num_out}, {126'b0, e.pntr});
      end
    end
    if (!reset && cpu_rd_data_vld) begin
      if (rd_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL unexpected_read: got %h expected none", cpu_rd_data);
      end else begin
        r = rd_q.pop_front();
        checkOutput("cpu_rd_data", {96'b0, cpu_rd_data}, {96'b0, r});
      end
    end
  end

  initial begin
    logic [127:0] held;
    reset        = 1'b1;
    data_in      = '0;
    data_in_vld  = 1'b0;
    pntr_num_in  = 2'd0;
    data_out_rdy = 1'b0;
    cpu_rd       = 1'b0;
    cpu_addr     = 1'b0;
    model_reset();

    #2;
    checkOutput("rst_data_out", data_out, 128'h0);
    checkOutput("rst_out_vld", {127'b0, data_out_vld}, 128'h0);
    checkOutput("rst_pntr_out", {126'b0, pntr_num_out}, 128'h0);
    checkOutput("rst_rd_data", {96'b0, cpu_rd_data}, 128'h0);
    checkOutput("rst_rd_vld", {127'b0, cpu_rd_data_vld}, 128'h0);
    checkOutput("rst_in_rdy", {127'b0, data_in_rdy}, 128'h1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Identity vector against a hand-derived constant.
    applyStimulus(1'b1, 128'h000102030405060708090a0b0c0d0e0f, 2'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 2'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("identity_data", data_out, 128'h000d0a07_04010e0b_0805020f_0c090603);
    checkOutput("identity_vld", {127'b0, data_out_vld}, 128'h1);
    checkOutput("identity_pntr", {126'b0, pntr_num_out}, 128'h0);

    // Back-to-back across all four pointers, then counter read.
    for (int p = 0; p < 4; p++) applyStimulus(1'b1, rand128(), p[1:0], 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 2'd0, 1'b1, 1'b1, 1'b0);

    // Backpressure: load then stall three cycles with input still offered.
    applyStimulus(1'b1, rand128(), 2'd1, 1'b0, 1'b0, 1'b0);
    held = ref_inv_shift(data_in);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, rand128(), 2'd3, 1'b0, 1'b0, 1'b0);
      checkOutput("stall_hold", data_out, held);
    end
    applyStimulus(1'b0, '0, 2'd0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 2'd0, 1'b1, 1'b1, 1'b1);

    // Read colliding with an accept, then a follow-up debug read.
    applyStimulus(1'b1, rand128(), 2'd2, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 2'd0, 1'b1, 1'b1, 1'b1);

    // Async reset while a result is parked and counters are nonzero.
    applyStimulus(1'b1, rand128(), 2'd3, 1'b0, 1'b0, 1'b0);
    data_in_vld = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_vld", {127'b0, data_out_vld}, 128'h0);
    checkOutput("async_rst_data", data_out, 128'h0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus(1'b0, '0, 2'd0, 1'b1, 1'b1, 1'b0);

    // Counter wrap on pointer 2.
    for (int i = 0; i < 256; i++) applyStimulus(1'b1, rand128(), 2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 2'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, rand128(), 2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 2'd0, 1'b1, 1'b1, 1'b0);

    // Randomized traffic with random backpressure and reads.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), rand128(), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0),
                    1'($urandom_range(0, 1)));
    end

    // Drain with a bounded number of cycles.
    for (int i = 0; i < 20 && (exp_q.size() != 0 || rd_q.size() != 0); i++)
      applyStimulus(1'b0, '0, 2'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 2'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("drain_out_q", 128'(exp_q.size()), 128'h0);
    checkOutput("drain_rd_q", 128'(rd_q.size()), 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/inv_shift_rows.md
Name: inv_shift_rows

Overview:
Decryption-path counterpart of the encryption shift-rows stage. It applies the AES InvShiftRows permutation (row r rotated right by r bytes) to one 128-bit state per accepted transfer. The result is held in a single registered pipeline stage with valid/ready flow control, and the 2-bit key-pointer tag travels alongside the data. Per-pointer transfer counters and sticky debug flags are exposed through the CPU read port for the decrypt datapath.

Parameters:
BLOCK_DATA_WIDTH, 128, state width; fixed, any other value is illegal.
CPU_DATA_WIDTH, 32, CPU read data width.
CNT_WIDTH, 8, width of each per-pointer counter; 4*CNT_WIDTH must equal CPU_DATA_WIDTH.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high reset.
data_in  in  128  input state; byte k = bits [127-8k -: 8], row = k mod 4, col = k/4.
data_in_vld  in  1  input valid.
data_in_rdy  out  1  input ready.
pntr_num_in  in  2  key-pointer tag accompanying data_in.
data_out  out  128  permuted state.
data_out_vld  out  1  output valid.
data_out_rdy  in  1  downstream ready.
pntr_num_out  out  2  tag accompanying data_out.
cpu_rd  in  1  CPU read strobe, single cycle.
cpu_addr  in  1  0 = counter register, 1 = debug register.
cpu_rd_data  out  32  read data.
cpu_rd_data_vld  out  1  read data valid.

Behaviour:
- Reset (async assert): data_out=0, data_out_vld=0, pntr_num_out=0, all counters=0, debug=0, cpu_rd_data=0, cpu_rd_data_vld=0.
- Permutation: out(r,c) = in(r,(c-r) mod 4). Pure byte routing, no arithmetic.
- data_in_rdy = !data_out_vld || data_out_rdy. This path is combinational.
- Accept when data_in_vld && data_in_rdy. On the next edge, data_out, pntr_num_out and data_out_vld=1 are loaded. Latency is 1 cycle, and one state per cycle is sustained when downstream is always ready.
- When data_out_vld && data_out_rdy with no accept, data_out_vld goes to 0. data_out holds its last value.
- Stall (data_out_vld && !data_out_rdy): data_out and pntr_num_out hold stable; no input is accepted.
- Counters: cnt[p] occupies bits [8p+7:8p]. On each accept, cnt[pntr_num_in] increments by 1 and wraps 255 -> 0. Only one counter changes per cycle.
- Debug register (bits 31:2 read 0):
  - bit0 RD_AND_VALID: set when cpu_rd and an accept occur in the same cycle.
  - bit1 STALL_SEEN: set when data_in_vld=1 and data_in_rdy=0.
- CPU read: on cpu_rd, the next cycle gives cpu_rd_data = addressed register value as of the cpu_rd cycle, with cpu_rd_data_vld=1 for that one cycle. Without cpu_rd, cpu_rd_data_vld=0 and cpu_rd_data holds its value.
- Debug is clear-on-read. A read at cpu_addr=1 clears both bits on the same edge the data is captured. If a set condition occurs in that same cycle, set wins and the bit stays 1.
- Counters are read-only and are not cleared by reads.
- A count update and a read in the same cycle: the read returns the pre-increment value.
- Reset mid-transfer: in-flight data is discarded, data_out_vld drops immediately (async), and counters and debug clear. On the first edge after deassertion, data_in_rdy=1.

Decomposition:
- aes_pkg holds BLOCK_DATA_WIDTH, CPU_DATA_WIDTH, CNT_WIDTH, the byte-slice constants (word/byte index), cpu_addr codes (CNT_REG=0, DBG_REG=1), debug bit indices (DBG_RD_AND_VALID=0, DBG_STALL_SEEN=1), and an inverse-shift-rows permutation function. The encrypt shift-rows stage shares the same slice constants.
- One sub-module, inv_shift_rows_csr, holds the counters, debug flags and read mux. The top level keeps the datapath register and handshake.

Test Plan:
- Identity vector: data_in=0x000102030405060708090a0b0c0d0e0f, vld=1, pntr=0, out_rdy=1 -> next cycle data_out=0x000d0a07_04010e0b_0805020f_0c090603 with vld=1, pntr_num_out=0.
- Back-to-back: 4 states with pntr 0,1,2,3 on consecutive cycles, out_rdy=1 -> 4 consecutive outputs with matching tags; a counter read then returns 0x01010101.
- Backpressure: hold out_rdy=0 for 3 cycles while data_in_vld=1 -> data_out stable and data_in_rdy=0; a debug read returns 0x2, and a second debug read returns 0x0.
- Wrap: 256 accepts with pntr=2 -> a counter read returns 0x00000000; 257 accepts -> 0x00010000.
- Simultaneous events: a debug read in the same cycle as an accept -> returned data bit0=0 (pre-update value), and a following debug read returns 0x1 (set beat clear).
- Async reset asserted while data_out_vld=1 and counters are nonzero -> data_out_vld=0 without a clock edge; after release, a counter read returns 0 and data_in_rdy=1.
